// File: rtl/divn_counter.sv
// Programmable divide-by-N counter: cnt runs 0..term, wraps to 0, and pulses tc on the wrap cycle.
// Latency: cnt/term are registered; tc is combinational from en, cnt and term (zero latency for cascading).
// Backpressure: none; en stalls the count, and chained stages use the previous tc as their en.
// Optional feature: define DIVCNT_SQW_EN to build the sqw toggle flop (otherwise sqw is tied low).
module divn_counter #(
    parameter int WIDTH    = 4,
    parameter int DEF_TERM = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_term,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] term,
    output logic             tc,
    output logic             sqw
);

    // Terminal value after reset, sized to the counter width.
    localparam logic [WIDTH-1:0] DEF_TERM_W = WIDTH'(DEF_TERM);
    localparam logic [WIDTH-1:0] ONE_W      = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] term_q;
    logic [WIDTH-1:0] term_d;
    logic             at_term;

    // Compare with >= so that loading a term below the current count wraps
    // on the next enabled cycle instead of running up to 2**WIDTH.
    assign at_term = (cnt_q >= term_q);
    assign tc      = en & at_term;

    // Next count: clear wins over enable; the wrap decision uses the old term,
    // so a load in the same cycle only affects the following cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (at_term) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + ONE_W;
            end
        end
    end

    // Next terminal value: load is independent of clear and enable.
    always_comb begin
        term_d = term_q;
        if (ld) begin
            term_d = ld_term;
        end
    end

    // Count and terminal registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            term_q <= DEF_TERM_W;
        end else begin
            cnt_q  <= cnt_d;
            term_q <= term_d;
        end
    end

    assign cnt  = cnt_q;
    assign term = term_q;

`ifdef DIVCNT_SQW_EN
    logic sqw_q;
    logic sqw_d;

    // Square wave flips once per wrap; clr does not touch it.
    always_comb begin
        sqw_d = sqw_q;
        if (tc) begin
            sqw_d = ~sqw_q;
        end
    end

    // Square-wave toggle register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sqw_q <= 1'b0;
        end else begin
            sqw_q <= sqw_d;
        end
    end

    assign sqw = sqw_q;
`else
    assign sqw = 1'b0;
`endif

endmodule

// File: tb/tb_divn_counter.sv
// Directed bench for divn_counter: reset, hold/clear, reload, edge ratios, async reset, cascade.
// Inputs change at negedge (+1 settle); registered state and tc are checked away from posedge.
// Expected values are hand-computed from the divide-by-N behaviour.
module tb_divn_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic       ld;
    logic [3:0] ld_term;
    logic [3:0] cnt;
    logic [3:0] term;
    logic       tc;
    logic       sqw;

    logic       c_en;
    logic [3:0] s1_cnt;
    logic [3:0] s1_term;
    logic       s1_tc;
    logic       s1_sqw;
    logic [3:0] s2_cnt;
    logic [3:0] s2_term;
    logic       s2_tc;
    logic       s2_sqw;

    int n_cmp;
    int n_err;
    int tc_seen;

    divn_counter #(.WIDTH(4), .DEF_TERM(2)) u_dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .ld(ld), .ld_term(ld_term),
        .cnt(cnt), .term(term), .tc(tc), .sqw(sqw)
    );

    divn_counter #(.WIDTH(4), .DEF_TERM(9)) u_s1 (
        .clk(clk), .rst(rst), .en(c_en), .clr(1'b0), .ld(1'b0), .ld_term(4'd0),
        .cnt(s1_cnt), .term(s1_term), .tc(s1_tc), .sqw(s1_sqw)
    );

    divn_counter #(.WIDTH(4), .DEF_TERM(9)) u_s2 (
        .clk(clk), .rst(rst), .en(s1_tc), .clr(1'b0), .ld(1'b0), .ld_term(4'd0),
        .cnt(s2_cnt), .term(s2_term), .tc(s2_tc), .sqw(s2_sqw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, need finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Drive the synchronous inputs and let combinational outputs settle.
    task automatic drv(input logic e, input logic c, input logic l, input logic [3:0] lt);
        en      = e;
        clr     = c;
        ld      = l;
        ld_term = lt;
        #1;
    endtask

    // Advance one clock; return just after the following negedge.
    task automatic nxt();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        tc_seen = 0;
        rst     = 1'b1;
        c_en    = 1'b0;
        en      = 1'b0;
        clr     = 1'b0;
        ld      = 1'b0;
        ld_term = 4'd0;

        // 1: reset state and default divide-by-3
        @(negedge clk);
        #1;
        chk("rst_cnt", 32'(cnt), 0);
        chk("rst_term", 32'(term), 2);
        chk("rst_sqw", 32'(sqw), 0);
        chk("rst_tc_en0", 32'(tc), 0);
        drv(1'b1, 1'b0, 1'b0, 4'd0);
        chk("rst_tc_en1", 32'(tc), 0);
        rst = 1'b0;
        #1;
        for (int k = 1; k <= 9; k++) begin
            chk("def_cnt", 32'(cnt), (k - 1) % 3);
            chk("def_tc", 32'(tc), ((k - 1) % 3 == 2) ? 1 : 0);
            nxt();
            #1;
        end
        chk("def_cnt_end", 32'(cnt), 0);
        chk("def_term", 32'(term), 2);

        // 2: hold and clear
        nxt();
        #1;
        chk("hold_start", 32'(cnt), 1);
        drv(1'b0, 1'b0, 1'b0, 4'd0);
        for (int k = 0; k < 5; k++) begin
            chk("hold_tc", 32'(tc), 0);
            nxt();
            #1;
            chk("hold_cnt", 32'(cnt), 1);
        end
        drv(1'b1, 1'b0, 1'b0, 4'd0);
        nxt();
        #1;
        chk("clr_pre_cnt", 32'(cnt), 2);
        drv(1'b1, 1'b1, 1'b0, 4'd0);
        chk("clr_tc", 32'(tc), 1);
        nxt();
        #1;
        chk("clr_cnt", 32'(cnt), 0);

        // 3: reload below the current count
        drv(1'b0, 1'b0, 1'b1, 4'd9);
        nxt();
        #1;
        chk("ld9_term", 32'(term), 9);
        chk("ld9_cnt", 32'(cnt), 0);
        drv(1'b1, 1'b0, 1'b0, 4'd0);
        for (int k = 0; k < 7; k++) begin
            nxt();
        end
        #1;
        chk("cnt7", 32'(cnt), 7);
        drv(1'b1, 1'b0, 1'b1, 4'd3);
        chk("ld3_tc", 32'(tc), 0);
        nxt();
        #1;
        chk("ld3_cnt_old_term", 32'(cnt), 8);
        chk("ld3_term", 32'(term), 3);
        drv(1'b1, 1'b0, 1'b0, 4'd0);
        chk("below_tc", 32'(tc), 1);
        nxt();
        #1;
        chk("below_wrap", 32'(cnt), 0);
        for (int k = 0; k < 8; k++) begin
            chk("p4_cnt", 32'(cnt), k % 4);
            chk("p4_tc", 32'(tc), (k % 4 == 3) ? 1 : 0);
            nxt();
            #1;
        end

        // 4: edge ratios, term=0 and term=15
        drv(1'b1, 1'b0, 1'b1, 4'd0);
        chk("ld0_tc_pre", 32'(tc), 0);
        nxt();
        #1;
        chk("ld0_cnt", 32'(cnt), 1);
        chk("ld0_term", 32'(term), 0);
        drv(1'b1, 1'b0, 1'b0, 4'd0);
        chk("ld0_tc_wrap", 32'(tc), 1);
        nxt();
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("t0_cnt", 32'(cnt), 0);
            chk("t0_tc", 32'(tc), 1);
            nxt();
            #1;
        end
        drv(1'b0, 1'b0, 1'b1, 4'd15);
        chk("t0_tc_en0", 32'(tc), 0);
        nxt();
        #1;
        chk("ld15_term", 32'(term), 15);
        drv(1'b1, 1'b0, 1'b0, 4'd0);
        tc_seen = 0;
        for (int k = 0; k < 32; k++) begin
            chk("t15_cnt", 32'(cnt), k % 16);
            chk("t15_tc", 32'(tc), (k % 16 == 15) ? 1 : 0);
            if (tc) tc_seen++;
            nxt();
            #1;
        end
        chk("t15_tc_count", 32'(tc_seen), 2);
        chk("t15_wrap", 32'(cnt), 0);

        // 6: async reset mid-count, then square wave with default term
        drv(1'b0, 1'b1, 1'b1, 4'd9);
        nxt();
        #1;
        drv(1'b1, 1'b0, 1'b0, 4'd0);
        for (int k = 0; k < 5; k++) begin
            nxt();
        end
        #1;
        chk("mid_cnt5", 32'(cnt), 5);
        chk("mid_term9", 32'(term), 9);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_cnt", 32'(cnt), 0);
        chk("arst_term", 32'(term), 2);
        chk("arst_sqw", 32'(sqw), 0);
        nxt();
        #1;
        chk("arst_hold_cnt", 32'(cnt), 0);
        rst = 1'b0;
        drv(1'b1, 1'b0, 1'b0, 4'd0);
        for (int k = 1; k <= 12; k++) begin
            chk("sq_cnt", 32'(cnt), (k - 1) % 3);
`ifdef DIVCNT_SQW_EN
            chk("sqw_toggle", 32'(sqw), ((k - 1) / 3) % 2);
`else
            chk("sqw_tied", 32'(sqw), 0);
`endif
            nxt();
            #1;
        end

        // 5: two-stage cascade, 100 clocks
        drv(1'b0, 1'b0, 1'b0, 4'd0);
        c_en = 1'b1;
        #1;
        tc_seen = 0;
        for (int k = 1; k <= 100; k++) begin
            chk("c_s1_cnt", 32'(s1_cnt), (k - 1) % 10);
            chk("c_s1_tc", 32'(s1_tc), ((k - 1) % 10 == 9) ? 1 : 0);
            chk("c_s2_cnt", 32'(s2_cnt), ((k - 1) / 10) % 10);
            chk("c_s2_tc", 32'(s2_tc), (k == 100) ? 1 : 0);
            if (s2_tc) tc_seen++;
            nxt();
            #1;
        end
        c_en = 1'b0;
        #1;
        chk("c_s2_tc_count", 32'(tc_seen), 1);
        chk("c_s1_end", 32'(s1_cnt), 0);
        chk("c_s2_end", 32'(s2_cnt), 0);
        chk("c_s2_term", 32'(s2_term), 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
